// File: rtl/communicate_receive.sv
// communicate_receive: UART receive path (8N1, LSB first) feeding a
// first-word-fall-through byte FIFO for the packet parser.
// The line is synchronised through two flops. The FSM samples each bit at mid-bit,
// checks the stop bit, and tags the first byte after an idle gap as a frame start.
// Optional feature macro: PARITY_EVEN_EN. It adds an even-parity bit after bit 7
// and a Parity_Err output.
module communicate_receive #(
  parameter int CLK_FREQ       = 50000000,
  parameter int BAUD           = 921600,
  parameter int FIFO_DEPTH     = 16,
  parameter int FRAME_GAP_BITS = 10
) (
  input  logic                          CLOCK_50M,
  input  logic                          RST,
  input  logic                          Rx_Pin,
  input  logic                          Rd_En,
  output logic [7:0]                    Data,
  output logic                          Frame_Start_Sig,
  output logic                          Data_Valid,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count,
  output logic                          Frame_Err,
  output logic                          Overrun_Err
`ifdef PARITY_EVEN_EN
  ,
  output logic                          Parity_Err
`endif
);

  localparam int BIT_CYC  = CLK_FREQ / BAUD;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int GAP_CYC  = FRAME_GAP_BITS * BIT_CYC;
  localparam int CYC_W    = $clog2(BIT_CYC + 1);
  localparam int GAP_W    = $clog2(GAP_CYC + 1);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  localparam logic [CYC_W-1:0] BIT_LAST  = CYC_W'(BIT_CYC - 1);
  localparam logic [CYC_W-1:0] HALF_LAST = CYC_W'(HALF_CYC - 1);
  localparam logic [CYC_W-1:0] CYC_ZERO  = {CYC_W{1'b0}};
  localparam logic [CYC_W-1:0] CYC_ONE   = CYC_W'(1'b1);
  localparam logic [GAP_W-1:0] GAP_MAX   = GAP_W'(GAP_CYC);
  localparam logic [GAP_W-1:0] GAP_ZERO  = {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

`ifdef PARITY_EVEN_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4,
    ST_BREAK = 3'd5
  } state_t;
`endif

  // Even-parity bit that makes the total number of ones in {byte, bit} even.
  function automatic logic even_parity_bit(input logic [7:0] d);
    return ^d;
  endfunction

  // Line synchroniser and edge history.
  logic rx_meta_r;
  logic rx_sync_r;
  logic rx_prev_r;
  logic rx_fall_s;

  // Receiver state.
  state_t           state_r;
  logic [CYC_W-1:0] cyc_cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic             gap_flag_r;
  logic             push_r;
  logic [8:0]       push_data_r;
  logic             frame_err_r;
`ifdef PARITY_EVEN_EN
  logic             par_bad_r;
  logic             parity_err_r;
`endif

  // FIFO state.
  logic [8:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [8:0]       head_r;
  logic             valid_r;
  logic             overrun_r;

  logic             pop_s;
  logic             full_s;
  logic             wr_en_s;
  logic             overrun_s;
  logic [PTR_W-1:0] rd_ptr_nxt_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic [8:0]       head_nxt_s;

  // Two-flop synchroniser plus one history flop; the line idles high after reset.
  always_ff @(posedge CLOCK_50M) begin
    if (RST) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= Rx_Pin;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  assign rx_fall_s = rx_prev_r & ~rx_sync_r;

  // Receive FSM: start detect, mid-bit sampling, stop check, idle-gap tracking.
  always_ff @(posedge CLOCK_50M) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      cyc_cnt_r    <= CYC_ZERO;
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'h00;
      gap_cnt_r    <= GAP_ZERO;
      gap_flag_r   <= 1'b1;
      push_r       <= 1'b0;
      push_data_r  <= 9'h000;
      frame_err_r  <= 1'b0;
`ifdef PARITY_EVEN_EN
      par_bad_r    <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      push_r      <= 1'b0;
      frame_err_r <= 1'b0;
      gap_cnt_r   <= GAP_ZERO;
`ifdef PARITY_EVEN_EN
      parity_err_r <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          // Gap counter only runs while idle; a low line restarts it.
          if (!rx_sync_r) begin
            gap_cnt_r <= GAP_ZERO;
          end else if (gap_cnt_r != GAP_MAX) begin
            gap_cnt_r <= gap_cnt_r + GAP_ONE;
          end else begin
            gap_cnt_r  <= gap_cnt_r;
            gap_flag_r <= 1'b1;
          end
          if (rx_fall_s) begin
            state_r   <= ST_START;
            cyc_cnt_r <= CYC_ZERO;
            bit_idx_r <= 3'd0;
          end
        end
        ST_START: begin
          if (cyc_cnt_r == HALF_LAST) begin
            cyc_cnt_r <= CYC_ZERO;
            // A line that is high again at mid start bit was only a glitch.
            if (rx_sync_r) begin
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_DATA;
            end
          end else begin
            cyc_cnt_r <= cyc_cnt_r + CYC_ONE;
          end
        end
        ST_DATA: begin
          if (cyc_cnt_r == BIT_LAST) begin
            cyc_cnt_r <= CYC_ZERO;
            shift_r   <= {rx_sync_r, shift_r[7:1]};
            if (bit_idx_r == 3'd7) begin
`ifdef PARITY_EVEN_EN
              state_r <= ST_PARITY;
`else
              state_r <= ST_STOP;
`endif
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            cyc_cnt_r <= cyc_cnt_r + CYC_ONE;
          end
        end
`ifdef PARITY_EVEN_EN
        ST_PARITY: begin
          if (cyc_cnt_r == BIT_LAST) begin
            cyc_cnt_r    <= CYC_ZERO;
            par_bad_r    <= (even_parity_bit(shift_r) != rx_sync_r);
            parity_err_r <= (even_parity_bit(shift_r) != rx_sync_r);
            state_r      <= ST_STOP;
          end else begin
            cyc_cnt_r <= cyc_cnt_r + CYC_ONE;
          end
        end
`endif
        ST_STOP: begin
          if (cyc_cnt_r == BIT_LAST) begin
            cyc_cnt_r <= CYC_ZERO;
            if (rx_sync_r) begin
              state_r <= ST_IDLE;
`ifdef PARITY_EVEN_EN
              // A parity-failed byte is dropped even with a good stop bit.
              if (!par_bad_r) begin
                push_r      <= 1'b1;
                push_data_r <= {gap_flag_r, shift_r};
                gap_flag_r  <= 1'b0;
              end
`else
              push_r      <= 1'b1;
              push_data_r <= {gap_flag_r, shift_r};
              gap_flag_r  <= 1'b0;
`endif
            end else begin
              frame_err_r <= 1'b1;
              state_r     <= ST_BREAK;
            end
          end else begin
            cyc_cnt_r <= cyc_cnt_r + CYC_ONE;
          end
        end
        ST_BREAK: begin
          // Wait out a held-low line before looking for a new start bit.
          if (rx_sync_r) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign pop_s     = Rd_En & (count_r != CNT_ZERO);
  assign full_s    = (count_r == CNT_FULL);
  assign wr_en_s   = push_r & (~full_s | pop_s);
  assign overrun_s = push_r & full_s & ~pop_s;

  // Next read pointer, occupancy and head entry for the registered FWFT outputs.
  always_comb begin
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    head_nxt_s   = 9'h000;
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({wr_en_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
    // The slot being written this cycle becomes the head when nothing older remains.
    if (count_nxt_s == CNT_ZERO) begin
      head_nxt_s = 9'h000;
    end else if (wr_en_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = push_data_r;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge CLOCK_50M) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= push_data_r;
    end
  end

  // FIFO pointers, occupancy and registered head/status outputs.
  always_ff @(posedge CLOCK_50M) begin
    if (RST) begin
      wr_ptr_r  <= PTR_ZERO;
      rd_ptr_r  <= PTR_ZERO;
      count_r   <= CNT_ZERO;
      head_r    <= 9'h000;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r  <= rd_ptr_nxt_s;
      count_r   <= count_nxt_s;
      head_r    <= head_nxt_s;
      valid_r   <= (count_nxt_s != CNT_ZERO);
      overrun_r <= overrun_s;
    end
  end

  assign Data            = head_r[7:0];
  assign Frame_Start_Sig = head_r[8];
  assign Data_Valid      = valid_r;
  assign Fifo_Count      = count_r;
  assign Frame_Err       = frame_err_r;
  assign Overrun_Err     = overrun_r;
`ifdef PARITY_EVEN_EN
  assign Parity_Err      = parity_err_r;
`endif

endmodule

// File: tb/tb_communicate_receive.sv
// Directed bench for communicate_receive at the default link rate (BIT_CYC = 54).
module tb_communicate_receive;

  localparam int BIT = 54;
`ifdef PARITY_EVEN_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Negedge, counted from the start-bit launch, just before the edge that pushes the byte.
  localparam int PUSH_K = 3 + BIT / 2 + (NBITS - 1) * BIT;

  logic       clk = 1'b0;
  logic       RST;
  logic       Rx_Pin;
  logic       Rd_En;
  logic [7:0] Data;
  logic       Frame_Start_Sig;
  logic       Data_Valid;
  logic [4:0] Fifo_Count;
  logic       Frame_Err;
  logic       Overrun_Err;
`ifdef PARITY_EVEN_EN
  logic       Parity_Err;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int frame_err_cnt  = 0;
  int overrun_cnt    = 0;
  int parity_err_cnt = 0;
  int snap_fe;
  int snap_ov;
  int snap_pe;
  int cnt_min;
  int cnt_max;

  always #10 clk = ~clk;

  communicate_receive dut (
    .CLOCK_50M       (clk),
    .RST             (RST),
    .Rx_Pin          (Rx_Pin),
    .Rd_En           (Rd_En),
    .Data            (Data),
    .Frame_Start_Sig (Frame_Start_Sig),
    .Data_Valid      (Data_Valid),
    .Fifo_Count      (Fifo_Count),
    .Frame_Err       (Frame_Err),
    .Overrun_Err     (Overrun_Err)
`ifdef PARITY_EVEN_EN
    ,
    .Parity_Err      (Parity_Err)
`endif
  );

  // Count error pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (Frame_Err === 1'b1) frame_err_cnt++;
    if (Overrun_Err === 1'b1) overrun_cnt++;
`ifdef PARITY_EVEN_EN
    if (Parity_Err === 1'b1) parity_err_cnt++;
`endif
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_bits(input int n);
    repeat (n * BIT) @(negedge clk);
  endtask

  // Called on a negedge; drives start, data LSB first, [parity], stop, then idles high.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip);
    Rx_Pin = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      Rx_Pin = b[i];
      repeat (BIT) @(negedge clk);
    end
`ifdef PARITY_EVEN_EN
    Rx_Pin = (^b) ^ par_flip;
    repeat (BIT) @(negedge clk);
`endif
    Rx_Pin = stop_v;
    repeat (BIT) @(negedge clk);
    Rx_Pin = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1, 1'b0);
  endtask

  task automatic pop_one;
    Rd_En = 1'b1;
    @(negedge clk);
    Rd_En = 1'b0;
  endtask

  initial begin
    logic [8:0] exp_q [3];
    exp_q[0] = {1'b1, 8'hA5};
    exp_q[1] = {1'b0, 8'h3C};
    exp_q[2] = {1'b1, 8'h01};

    RST    = 1'b1;
    Rx_Pin = 1'b1;
    Rd_En  = 1'b0;
    repeat (4) @(negedge clk);
    check_val("rst_data", Data, 8'h00);
    check_val("rst_valid", Data_Valid, 1'b0);
    check_val("rst_count", Fifo_Count, 5'd0);
    check_val("rst_fs", Frame_Start_Sig, 1'b0);
    check_val("rst_errs", {Frame_Err, Overrun_Err}, 2'b00);
    RST = 1'b0;

    // 1: first byte after reset is a frame start
    idle_bits(20);
    send_byte(8'h55);
    check_val("t1_data", Data, 8'h55);
    check_val("t1_fs", Frame_Start_Sig, 1'b1);
    check_val("t1_count", Fifo_Count, 5'd1);
    check_val("t1_valid", Data_Valid, 1'b1);
    pop_one();
    check_val("t1_pop_count", Fifo_Count, 5'd0);

    // 2: back-to-back pair then gap-separated byte
    idle_bits(12);
    send_byte(8'hA5);
    send_byte(8'h3C);
    idle_bits(12);
    send_byte(8'h01);
    idle_bits(1);
    check_val("t2_count", Fifo_Count, 5'd3);
    for (int i = 0; i < 3; i++) begin
      check_val("t2_head", {Frame_Start_Sig, Data}, exp_q[i]);
      pop_one();
    end
    check_val("t2_empty", Data_Valid, 1'b0);
    pop_one();
    check_val("t2_pop_empty", Fifo_Count, 5'd0);

    // 3: short low glitch is a false start
    idle_bits(12);
    snap_fe = frame_err_cnt;
    snap_ov = overrun_cnt;
    Rx_Pin = 1'b0;
    repeat (10) @(negedge clk);
    Rx_Pin = 1'b1;
    idle_bits(2);
    check_val("t3_count", Fifo_Count, 5'd0);
    check_val("t3_ferr", frame_err_cnt - snap_fe, 0);
    check_val("t3_oerr", overrun_cnt - snap_ov, 0);

    // 4: stop bit low, then a good byte
    idle_bits(12);
    snap_fe = frame_err_cnt;
    send_frame(8'h81, 1'b0, 1'b0);
    idle_bits(1);
    check_val("t4_ferr", frame_err_cnt - snap_fe, 1);
    check_val("t4_count", Fifo_Count, 5'd0);
    idle_bits(12);
    send_byte(8'h7E);
    check_val("t4_data", Data, 8'h7E);
    check_val("t4_fs", Frame_Start_Sig, 1'b1);
    check_val("t4_count2", Fifo_Count, 5'd1);
    pop_one();

    // 5: overrun on the 17th byte, then push and pop in one cycle while full
    idle_bits(12);
    snap_ov = overrun_cnt;
    for (int i = 0; i < 17; i++) begin
      send_byte(8'(i));
    end
    idle_bits(1);
    check_val("t5_overrun", overrun_cnt - snap_ov, 1);
    check_val("t5_count", Fifo_Count, 5'd16);
    check_val("t5_head", {Frame_Start_Sig, Data}, {1'b1, 8'h00});
    cnt_min = 99;
    cnt_max = -1;
    fork
      send_byte(8'h11);
      begin
        for (int k = 1; k <= NBITS * BIT; k++) begin
          @(negedge clk);
          if (k > PUSH_K - 20) begin
            if (int'(Fifo_Count) < cnt_min) cnt_min = int'(Fifo_Count);
            if (int'(Fifo_Count) > cnt_max) cnt_max = int'(Fifo_Count);
          end
          Rd_En = (k == PUSH_K);
        end
        Rd_En = 1'b0;
      end
    join
    idle_bits(1);
    check_val("t5_pp_min", cnt_min, 16);
    check_val("t5_pp_max", cnt_max, 16);
    check_val("t5_pp_overrun", overrun_cnt - snap_ov, 1);
    check_val("t5_pp_head", {Frame_Start_Sig, Data}, {1'b0, 8'h01});

    // 6: reset in the middle of bit 4 of 0xF0
    fork
      send_byte(8'hF0);
      begin
        repeat (5 * BIT + BIT / 2) @(negedge clk);
        RST = 1'b1;
        repeat (3) @(negedge clk);
        check_val("t6_rst_outs", {Data, Frame_Start_Sig, Data_Valid, Fifo_Count, Frame_Err, Overrun_Err}, 17'h0);
        RST = 1'b0;
      end
    join
    idle_bits(12);
    check_val("t6_no_push", Fifo_Count, 5'd0);
    send_byte(8'h0F);
    check_val("t6_data", Data, 8'h0F);
    check_val("t6_fs", Frame_Start_Sig, 1'b1);
    check_val("t6_count", Fifo_Count, 5'd1);

`ifdef PARITY_EVEN_EN
    // parity bit wrong for 0x03: error pulse, byte dropped
    idle_bits(12);
    snap_pe = parity_err_cnt;
    snap_fe = frame_err_cnt;
    send_frame(8'h03, 1'b1, 1'b1);
    idle_bits(1);
    check_val("par_err", parity_err_cnt - snap_pe, 1);
    check_val("par_count", Fifo_Count, 5'd1);
    check_val("par_ferr", frame_err_cnt - snap_fe, 0);
`else
    snap_pe = parity_err_cnt;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
